// File: rtl/cordic_pkg.sv
// Shared constants, lookup tables and state encoding for the CORDIC engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cordic_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_ITER   = 16;
   localparam int DEF_N_PROG = 8;
   localparam int DEF_IW     = DEF_WIDTH + 2;

   // Pre-scale for the CORDIC gain: 0.607253 in Q2.14.
   localparam logic signed [DEF_WIDTH-1:0] K_GAIN = 16'sd9949;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_OUT,
      ST_DONE
   } state_t;

   // atan(2^-i) in Q2.14.
   function automatic logic signed [DEF_WIDTH-1:0] atan_lut(input int unsigned idx);
      case (idx)
         0:       atan_lut = 16'sd12868;
         1:       atan_lut = 16'sd7596;
         2:       atan_lut = 16'sd4014;
         3:       atan_lut = 16'sd2037;
         4:       atan_lut = 16'sd1023;
         5:       atan_lut = 16'sd512;
         6:       atan_lut = 16'sd256;
         7:       atan_lut = 16'sd128;
         8:       atan_lut = 16'sd64;
         9:       atan_lut = 16'sd32;
         10:      atan_lut = 16'sd16;
         11:      atan_lut = 16'sd8;
         12:      atan_lut = 16'sd4;
         13:      atan_lut = 16'sd2;
         14:      atan_lut = 16'sd1;
         default: atan_lut = 16'sd0;
      endcase
   endfunction

   // Angle program: 0, pi/6, pi/4, pi/3, pi/2, -pi/6, -pi/4, -pi/2 in Q2.14.
   function automatic logic signed [DEF_WIDTH-1:0] prog_rom(input int unsigned idx);
      case (idx)
         0:       prog_rom = 16'sd0;
         1:       prog_rom = 16'sd8579;
         2:       prog_rom = 16'sd12868;
         3:       prog_rom = 16'sd17157;
         4:       prog_rom = 16'sd25736;
         5:       prog_rom = -16'sd8579;
         6:       prog_rom = -16'sd12868;
         default: prog_rom = -16'sd25736;
      endcase
   endfunction

   // Clamp the two-bit-wider internal value into the signed output range.
   function automatic logic signed [DEF_WIDTH-1:0] sat(input logic signed [DEF_IW-1:0] v);
      if (!v[DEF_IW-1] && (v[DEF_IW-2:DEF_WIDTH-1] != '0))
         sat = {1'b0, {(DEF_WIDTH-1){1'b1}}};
      else if (v[DEF_IW-1] && !(&v[DEF_IW-2:DEF_WIDTH-1]))
         sat = {1'b1, {(DEF_WIDTH-1){1'b0}}};
      else
         sat = v[DEF_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// One CORDIC rotation-mode micro-rotation: direction chosen by the sign of z.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module cordic_iter_stage
   import cordic_pkg::*;
#(
   parameter int IW = DEF_IW,
   parameter int SW = 4
) (
   input  logic signed [IW-1:0] i_x,
   input  logic signed [IW-1:0] i_y,
   input  logic signed [IW-1:0] i_z,
   input  logic        [SW-1:0] i_i,
   output logic signed [IW-1:0] o_x,
   output logic signed [IW-1:0] o_y,
   output logic signed [IW-1:0] o_z
);

   logic signed [IW-1:0] w_xs;
   logic signed [IW-1:0] w_ys;
   logic signed [IW-1:0] w_at;

   assign w_xs = i_x >>> i_i;
   assign w_ys = i_y >>> i_i;
   assign w_at = IW'(atan_lut(int'(i_i)));

   // Rotate towards z = 0 using the un-updated x/y.
   always_comb begin
      o_x = i_x;
      o_y = i_y;
      o_z = i_z;
      if (!i_z[IW-1]) begin
         o_x = i_x - w_ys;
         o_y = i_y + w_xs;
         o_z = i_z - w_at;
      end else begin
         o_x = i_x + w_ys;
         o_y = i_y - w_xs;
         o_z = i_z + w_at;
      end
   end

endmodule

// File: rtl/cordic_processor.sv
// Iterative CORDIC engine: walks the angle ROM and emits saturated cos/sin per angle.
// Latency: ITER+2 cycles per angle; first res_valid 19 edges after run is first seen.
// Backpressure: none; results are one-cycle strobes, run low aborts to idle at once.
module cordic_processor
   import cordic_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ITER   = DEF_ITER,
   parameter int N_PROG = DEF_N_PROG
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   output logic                      busy,
   output logic                      done,
   output logic                      res_valid,
   output logic [$clog2(N_PROG)-1:0] res_idx,
   output logic [WIDTH-1:0]          cos_out,
   output logic [WIDTH-1:0]          sin_out
);

   localparam int IW = WIDTH + 2;
   localparam int SW = $clog2(ITER);
   localparam int PW = $clog2(N_PROG);

   state_t               r_state;
   state_t               w_next;
   logic                 w_abort;
   logic [PW-1:0]        r_pc;
   logic [SW-1:0]        r_i;
   logic signed [IW-1:0] r_x, r_y, r_z;
   logic signed [IW-1:0] w_x, w_y, w_z;
   logic                 r_busy, r_done, r_vld;
   logic [PW-1:0]        r_idx;
   logic [WIDTH-1:0]     r_cos, r_sin;

   cordic_iter_stage #(.IW(IW), .SW(SW)) u_stage (
      .i_x (r_x),
      .i_y (r_y),
      .i_z (r_z),
      .i_i (r_i),
      .o_x (w_x),
      .o_y (w_y),
      .o_z (w_z)
   );

   // Dropping run anywhere outside IDLE discards the program in flight.
   assign w_abort = !run && (r_state != ST_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode; abort overrides every sequencing decision.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (run) w_next = ST_LOAD;
         ST_LOAD: w_next = ST_ITER;
         ST_ITER: if (r_i == SW'(ITER - 1)) w_next = ST_OUT;
         ST_OUT:  w_next = (r_pc == PW'(N_PROG - 1)) ? ST_DONE : ST_LOAD;
         ST_DONE: w_next = ST_DONE;
         default: w_next = ST_IDLE;
      endcase
      if (w_abort) w_next = ST_IDLE;
   end

   // Datapath and registered status/result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n || w_abort) begin
         r_pc   <= '0;
         r_i    <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_vld  <= 1'b0;
         r_idx  <= '0;
         r_cos  <= '0;
         r_sin  <= '0;
      end else begin
         r_vld  <= (r_state == ST_OUT);
         r_busy <= (r_state == ST_LOAD) || (r_state == ST_ITER) || (r_state == ST_OUT);
         r_done <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: r_pc <= '0;
            ST_LOAD: begin
               r_x <= IW'(K_GAIN);
               r_y <= '0;
               r_z <= IW'(prog_rom(int'(r_pc)));
               r_i <= '0;
            end
            ST_ITER: begin
               r_x <= w_x;
               r_y <= w_y;
               r_z <= w_z;
               r_i <= r_i + SW'(1);
            end
            ST_OUT: begin
               r_cos <= sat(r_x);
               r_sin <= sat(r_y);
               r_idx <= r_pc;
               if (r_pc != PW'(N_PROG - 1)) r_pc <= r_pc + PW'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign res_valid = r_vld;
   assign res_idx   = r_idx;
   assign cos_out   = r_cos;
   assign sin_out   = r_sin;

endmodule

// File: tb/tb_cordic_processor.sv
// Directed bench for cordic_processor: timing, accuracy, done hold, abort and reset.
// Latency: checks first result 19 edges after run and 18-edge spacing.
// Backpressure: n/a; every wait is bounded by a fixed cycle loop.
module tb_cordic_processor;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               run;
   logic               busy;
   logic               done;
   logic               res_valid;
   logic [2:0]         res_idx;
   logic signed [15:0] cos_out;
   logic signed [15:0] sin_out;

   int vectors     = 0;
   int miscompares = 0;

   int cos_exp [8] = '{16384, 14189, 11585, 8192, 0, 14189, 11585, 0};
   int sin_exp [8] = '{0, 8192, 11585, 14189, 16384, -8192, -11585, -16384};

   cordic_processor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .busy      (busy),
      .done      (done),
      .res_valid (res_valid),
      .res_idx   (res_idx),
      .cos_out   (cos_out),
      .sin_out   (sin_out)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_near(input string tag, input int got, input int exp);
      vectors++;
      assert ((got - exp <= 8) && (exp - got <= 8)) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d +/-8", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".done"}, int'(done), 0);
      check({tag, ".res_valid"}, int'(res_valid), 0);
      check({tag, ".res_idx"}, int'(res_idx), 0);
      check({tag, ".cos"}, int'(cos_out), 0);
      check({tag, ".sin"}, int'(sin_out), 0);
   endtask

   initial begin
      int k;
      int bad;
      int first_n;

      // Reset state.
      rst_n = 1'b0;
      run   = 1'b0;
      tick;
      tick;
      check_idle("reset");

      // Idle with run low: nothing may start.
      rst_n = 1'b1;
      bad = 0;
      for (int n = 0; n < 50; n++) begin
         tick;
         if (busy || done || res_valid) bad++;
      end
      check("idle_run_low", bad, 0);

      // Full program: 8 results, 18 apart, first on the 19th edge.
      run = 1'b1;
      k = 0;
      for (int n = 1; n <= 146; n++) begin
         tick;
         if (n == 145) check("done_not_early", int'(done), 0);
         if (res_valid) begin
            if (k < 8) begin
               check("res_time", n, 19 + 18 * k);
               check("res_idx", int'(res_idx), k);
               check_near("cos", int'(cos_out), cos_exp[k]);
               check_near("sin", int'(sin_out), sin_exp[k]);
            end
            k++;
         end
      end
      check("res_count", k, 8);
      check("done_after_last", int'(done), 1);
      check("busy_after_last", int'(busy), 0);

      // DONE holds with run high; no restart.
      bad = 0;
      for (int n = 0; n < 100; n++) begin
         tick;
         if (!done || busy || res_valid) bad++;
      end
      check("done_hold", bad, 0);
      check_near("hold_sin", int'(sin_out), -16384);

      // run low leaves DONE and clears the held result.
      run = 1'b0;
      tick;
      check_idle("done_exit");

      // Restart, then abort mid-program at cycle 40.
      run = 1'b1;
      k = 0;
      for (int n = 1; n <= 40; n++) begin
         tick;
         if (res_valid) k++;
      end
      check("pulses_before_abort", k, 2);
      check("busy_before_abort", int'(busy), 1);
      run = 1'b0;
      tick;
      check_idle("abort");

      // Raising run again restarts from index 0.
      run = 1'b1;
      first_n = 0;
      for (int n = 1; n <= 30; n++) begin
         tick;
         if (res_valid && first_n == 0) begin
            first_n = n;
            check("restart_idx", int'(res_idx), 0);
            check_near("restart_cos", int'(cos_out), 16384);
         end
      end
      check("restart_time", first_n, 19);

      // Reset mid-ITER with run held high.
      rst_n = 1'b0;
      tick;
      check_idle("reset_mid_iter");
      bad = 0;
      for (int n = 0; n < 3; n++) begin
         tick;
         if (busy || done || res_valid || cos_out != 0) bad++;
      end
      check("reset_ignores_run", bad, 0);

      // Release reset with run high: program starts from scratch.
      rst_n = 1'b1;
      first_n = 0;
      for (int n = 1; n <= 25; n++) begin
         tick;
         if (res_valid && first_n == 0) begin
            first_n = n;
            check("post_reset_idx", int'(res_idx), 0);
         end
      end
      check("post_reset_time", first_n, 19);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
